// File: rtl/apb_req_pkg.sv
// rtl/apb_req_pkg.sv - shared types and constants for the APB request master
package apb_req_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Read data returned when a transfer is aborted because the slave never answered
    localparam logic [31:0] APB_TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/apb_req_master_if.sv
// rtl/apb_req_master_if.sv - request/response and APB signals of the request master
interface apb_req_master_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic                      req_write_i;
    logic [APB_ADDR_WIDTH-1:0] req_addr_i;
    logic [APB_DATA_WIDTH-1:0] req_wdata_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      psel_o;
    logic                      penable_o;
    logic                      pwrite_o;
    logic [APB_ADDR_WIDTH-1:0] paddr_o;
    logic [APB_DATA_WIDTH-1:0] pwdata_o;
    logic [APB_DATA_WIDTH-1:0] prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;

    // View of the request master itself
    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    // View of the surroundings: requester plus APB slave
    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

endinterface

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - saturating wait-state counter with expiry flag
module apb_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW     = (LIMIT > 0) ? (($clog2(LIMIT + 1) > 0) ? $clog2(LIMIT + 1) : 1) : 1;
    localparam int LAST_I = (LIMIT > 0) ? LIMIT - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    logic [CW-1:0] cnt;

    // Count stalled cycles; saturate instead of wrapping so expiry cannot re-arm
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Expiry is the last permitted stalled cycle; a zero limit never expires
    assign expired = (LIMIT > 0) && (cnt == LAST);

endmodule

// File: rtl/apb_req_master.sv
// rtl/apb_req_master.sv - valid/ready request to APB transfer initiator with timeout
module apb_req_master
    import apb_req_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    apb_req_master_if.master     bus
);
    apb_state_e state, state_next;
    logic       accept;
    logic       complete;
    logic       abort;
    logic       rsp_done;
    logic       tmr_clear;
    logic       tmr_enable;
    logic       tmr_expired;

    // The counter only runs during ACCESS, so it is fresh for every transfer
    assign tmr_clear  = (state != ACCESS);
    assign tmr_enable = (state == ACCESS) && !bus.pready_i;

    apb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    assign bus.req_ready_o = (state == IDLE);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and single-cycle event strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        rsp_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                // A slave answering on the expiry cycle still completes normally
                if (bus.pready_i) begin
                    complete   = 1'b1;
                    state_next = RESP;
                end else if (tmr_expired) begin
                    abort      = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // APB drive registers and the held response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.psel_o      <= 1'b0;
            bus.penable_o   <= 1'b0;
            bus.pwrite_o    <= 1'b0;
            bus.paddr_o     <= '0;
            bus.pwdata_o    <= '0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_rdata_o <= '0;
        end else begin
            if (accept) begin
                bus.paddr_o  <= bus.req_addr_i;
                bus.pwdata_o <= bus.req_wdata_i;
                bus.pwrite_o <= bus.req_write_i;
                bus.psel_o   <= 1'b1;
            end
            if (state == SETUP) begin
                bus.penable_o <= 1'b1;
            end
            if (complete || abort) begin
                bus.psel_o      <= 1'b0;
                bus.penable_o   <= 1'b0;
                bus.rsp_valid_o <= 1'b1;
                if (complete) begin
                    bus.rsp_err_o   <= bus.pslverr_i;
                    bus.rsp_rdata_o <= bus.pwrite_o ? '0 : bus.prdata_i;
                end else begin
                    bus.rsp_err_o   <= 1'b1;
                    bus.rsp_rdata_o <= APB_DATA_WIDTH'(APB_TIMEOUT_RDATA);
                end
            end
            if (rsp_done) begin
                bus.rsp_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// tb/tb_apb_req_master.sv - scoreboard bench for apb_req_master
module tb_apb_req_master;
    localparam int T = 4;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
        int          hold;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];

    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    int          cur_waits;
    logic        cur_slverr;
    logic [31:0] cur_prdata;

    apb_req_master_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus ();

    apb_req_master #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request; the expected response follows from the transfer plan alone
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic slverr, input logic [31:0] prd,
                         input int hold, input bit expect_rsp);
        int   budget;
        bit   got;
        exp_t e;
        budget = 0;
        got    = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_write_i = wr;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wdata;
        while (!got) begin
            if (bus.req_ready_o === 1'b1) begin
                got = 1'b1;
            end else begin
                budget++;
                if (budget > 200) break;
                @(negedge clk);
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_accept: got no acceptance expected acceptance within 200 cycles");
            bus.req_valid_i = 1'b0;
            return;
        end
        cur_write  = wr;
        cur_addr   = addr;
        cur_wdata  = wdata;
        cur_waits  = waits;
        cur_slverr = slverr;
        cur_prdata = prd;
        if (expect_rsp) begin
            if (waits < T) begin
                e.err   = slverr;
                e.rdata = wr ? 32'h0 : prd;
                e.lat   = 2 + waits + 1;
            end else begin
                e.err   = 1'b1;
                e.rdata = 32'hDEADBEEF;
                e.lat   = 2 + T;
            end
            e.acc  = cyc;
            e.hold = hold;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    // APB slave model: answers after the planned number of wait states
    initial begin
        int acc_n;
        acc_n = 0;
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
        bus.prdata_i  = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.psel_o === 1'b1) begin
                chk("apb_paddr", bus.paddr_o, cur_addr);
                chk("apb_pwrite", bus.pwrite_o, cur_write);
                if (cur_write) chk("apb_pwdata", bus.pwdata_o, cur_wdata);
            end
            if (!rst && bus.psel_o === 1'b1 && bus.penable_o === 1'b1) begin
                bus.pready_i  = (acc_n == cur_waits);
                bus.pslverr_i = cur_slverr;
                bus.prdata_i  = cur_prdata;
                acc_n++;
            end else begin
                bus.pready_i  = 1'b0;
                bus.pslverr_i = $urandom_range(0, 1);
                bus.prdata_i  = $urandom;
                acc_n = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard when a response appears, then checks it holds
    initial begin
        logic prev;
        bit   have_e;
        int   hold_cnt;
        exp_t e;
        prev     = 1'b0;
        have_e   = 1'b0;
        hold_cnt = 0;
        bus.rsp_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev     = 1'b0;
                hold_cnt = 0;
                bus.rsp_ready_i = 1'b1;
                continue;
            end
            if (bus.rsp_valid_o === 1'b1 && !prev) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    have_e = 1'b0;
                    $display("FAIL unexpected_rsp: got rsp_valid expected none (rdata %0h)", bus.rsp_rdata_o);
                end else begin
                    e      = sb_q.pop_front();
                    have_e = 1'b1;
                    chk("rsp_err", bus.rsp_err_o, e.err);
                    chk("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                    chk("rsp_latency", cyc - e.acc, e.lat);
                    hold_cnt = e.hold;
                end
            end else if (bus.rsp_valid_o === 1'b1) begin
                if (have_e) begin
                    chk("rsp_err_stable", bus.rsp_err_o, e.err);
                    chk("rsp_rdata_stable", bus.rsp_rdata_o, e.rdata);
                end
                chk("req_ready_while_rsp", bus.req_ready_o, 1'b0);
                if (hold_cnt > 0) hold_cnt--;
            end
            prev = bus.rsp_valid_o;
            bus.rsp_ready_i = (hold_cnt == 0);
        end
    end

    initial begin
        int budget;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        cur_write  = 1'b0;
        cur_addr   = '0;
        cur_wdata  = '0;
        cur_waits  = 0;
        cur_slverr = 1'b0;
        cur_prdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_psel", bus.psel_o, 1'b0);
        chk("reset_penable", bus.penable_o, 1'b0);
        chk("reset_pwrite", bus.pwrite_o, 1'b0);
        chk("reset_paddr", bus.paddr_o, 32'h0);
        chk("reset_pwdata", bus.pwdata_o, 32'h0);
        chk("reset_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("reset_rsp_err", bus.rsp_err_o, 1'b0);
        chk("reset_rsp_rdata", bus.rsp_rdata_o, 32'h0);
        chk("reset_req_ready", bus.req_ready_o, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Directed: zero-wait read, 3-wait write, slave error, timeout, pready on the expiry cycle, backpressure
        issue(1'b0, 32'h1A10_0004, 32'h0,          0, 1'b0, 32'h1234_5678, 0, 1'b1);
        issue(1'b1, 32'h1A10_1000, 32'hCAFE_F00D, 3, 1'b0, 32'h5555_AAAA, 0, 1'b1);
        issue(1'b0, 32'h1A10_2000, 32'h0,          0, 1'b1, 32'h0BAD_0BAD, 0, 1'b1);
        issue(1'b0, 32'h1A10_3000, 32'h0,          9, 1'b0, 32'h7777_7777, 0, 1'b1);
        issue(1'b1, 32'h1A10_3004, 32'h1357_9BDF, 9, 1'b0, 32'h7777_7777, 0, 1'b1);
        issue(1'b0, 32'h1A10_4000, 32'h0,          T - 1, 1'b0, 32'h4444_0004, 0, 1'b1);
        issue(1'b0, 32'h1A10_5000, 32'h0,          1, 1'b0, 32'h8BAD_F00D, 5, 1'b1);
        issue(1'b1, 32'h1A10_5004, 32'h2468_ACE0, 0, 1'b0, 32'h0,          0, 1'b1);

        // Randomised transfers with random wait states, errors and backpressure
        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 6),
                  ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3), 1'b1);
        end

        budget = 0;
        while (sb_q.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_before_reset", sb_q.size(), 0);
        repeat (3) @(negedge clk);

        // Reset in the middle of ACCESS: no response may appear afterwards
        issue(1'b0, 32'h1A10_6000, 32'h0, 20, 1'b0, 32'h6666_6666, 0, 1'b0);
        budget = 0;
        while (!(bus.psel_o === 1'b1 && bus.penable_o === 1'b1) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("reach_access", bus.penable_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_psel", bus.psel_o, 1'b0);
        chk("async_rst_penable", bus.penable_o, 1'b0);
        chk("async_rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("async_rst_req_ready", bus.req_ready_o, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_rsp_after_reset", bus.rsp_valid_o, 1'b0);

        issue(1'b0, 32'h1A10_7000, 32'h0,          2, 1'b0, 32'hA5A5_5A5A, 0, 1'b1);
        issue(1'b1, 32'h1A10_7004, 32'hFEED_BEEF, 0, 1'b0, 32'h0,          1, 1'b1);

        budget = 0;
        while (sb_q.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_final", sb_q.size(), 0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
